// File: rtl/gray_pkg.sv
// gray_pkg: shared default widths, requester id type and the binary-to-Gray function.
package gray_pkg;
  localparam int W_DEF = 10;
  localparam int CW_DEF = 8;
  typedef logic req_id_t;
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction
endpackage

// File: rtl/gray_enc_core.sv
// gray_enc_core: purely combinational W-bit binary-to-Gray encoder (W <= 32).
module gray_enc_core
  import gray_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] bin_i,
  output logic [W-1:0] gray_o
);
  assign gray_o = W'(bin2gray(32'(bin_i)));
endmodule

// File: rtl/gray_enc_arbiter.sv
// gray_enc_arbiter: round-robin arbiter for two requesters sharing one Gray encoder,
// with a registered, id-tagged result and saturating per-requester accept counters.
module gray_enc_arbiter
  import gray_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_bin,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_bin,
  output logic          req1_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_gray,
  output req_id_t       out_id,
  input  logic          out_ready,
  output logic [CW-1:0] acc_cnt0,
  output logic [CW-1:0] acc_cnt1
);
  logic          space, grant0, grant1, acc0, acc1;
  logic [W-1:0]  enc_bin, enc_gray;
  logic          valid_q, valid_d;
  logic [W-1:0]  gray_q, gray_d;
  req_id_t       id_q, id_d, last_q, last_d;
  logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  assign space      = ~valid_q | out_ready;
  // Under contention the requester that did not win last time is granted.
  assign grant0     = req0_valid & (~req1_valid | last_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = grant0 & space;
  assign req1_ready = grant1 & space;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;
  assign enc_bin    = grant1 ? req1_bin : req0_bin;
  gray_enc_core #(.W(W)) u_enc (
    .bin_i (enc_bin),
    .gray_o(enc_gray)
  );
  always_comb begin
    valid_d = (acc0 | acc1) | (valid_q & ~out_ready);
    gray_d  = (acc0 | acc1) ? enc_gray : gray_q;
    id_d    = (acc0 | acc1) ? acc1 : id_q;
    last_d  = (acc0 | acc1) ? acc1 : last_q;
    cnt0_d  = (acc0 & ~&cnt0_q) ? cnt0_q + CW'(1) : cnt0_q;
    cnt1_d  = (acc1 & ~&cnt1_q) ? cnt1_q + CW'(1) : cnt1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      gray_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      valid_q <= valid_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
  assign out_valid = valid_q;
  assign out_gray  = gray_q;
  assign out_id    = id_q;
  assign acc_cnt0  = cnt0_q;
  assign acc_cnt1  = cnt1_q;
endmodule

// File: tb/tb_gray_enc_arbiter.sv
// tb_gray_enc_arbiter: directed plus random stimulus against a behavioural model;
// a second instance with CW=2 exercises counter saturation on the same stimulus.
module tb_gray_enc_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, out_ready;
  logic [9:0] req0_bin, req1_bin;
  logic       req0_ready, req1_ready, out_valid, out_id;
  logic [9:0] out_gray;
  logic [7:0] acc_cnt0, acc_cnt1;
  logic       s_r0, s_r1, s_ov, s_id;
  logic [9:0] s_gray;
  logic [1:0] s_cnt0, s_cnt1;
  int total = 0;
  int bad = 0;
  logic       m_valid, m_id, m_last;
  logic [9:0] m_gray;
  int         m_c0, m_c1, m_s0, m_s1;

  always #5 clk = ~clk;

  gray_enc_arbiter #(.W(10), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_bin(req0_bin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bin(req1_bin), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_gray(out_gray), .out_id(out_id), .out_ready(out_ready),
    .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
  );

  gray_enc_arbiter #(.W(10), .CW(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_bin(req0_bin), .req0_ready(s_r0),
    .req1_valid(req1_valid), .req1_bin(req1_bin), .req1_ready(s_r1),
    .out_valid(s_ov), .out_gray(s_gray), .out_id(s_id), .out_ready(out_ready),
    .acc_cnt0(s_cnt0), .acc_cnt1(s_cnt1)
  );

  function automatic logic [9:0] ref_gray(input logic [9:0] b);
    logic [9:0] g;
    for (int i = 0; i < 10; i++) g[i] = (i == 9) ? b[9] : b[i] ^ b[i+1];
    return g;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v0, input logic [9:0] b0, input logic v1,
                      input logic [9:0] b1, input logic ordy, input logic r);
    logic space, win, a0, a1;
    req0_valid = v0; req0_bin = b0; req1_valid = v1; req1_bin = b1;
    out_ready = ordy; rst = r;
    space = !m_valid || ordy;
    win   = (v0 && v1) ? !m_last : v1;
    a0    = !r && space && v0 && !win;
    a1    = !r && space && v1 && win;
    #2;
    if (!r) begin
      chk("ready0", req0_ready, space && v0 && !win);
      chk("ready1", req1_ready, space && v1 && win);
    end
    @(posedge clk); #1;
    if (r) begin
      m_valid = 0; m_gray = 0; m_id = 0; m_last = 1;
      m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    end else if (a0 || a1) begin
      m_valid = 1; m_gray = ref_gray(a1 ? b1 : b0); m_id = a1; m_last = a1;
      if (a0) begin m_c0 = (m_c0 < 255) ? m_c0 + 1 : 255; m_s0 = (m_s0 < 3) ? m_s0 + 1 : 3; end
      if (a1) begin m_c1 = (m_c1 < 255) ? m_c1 + 1 : 255; m_s1 = (m_s1 < 3) ? m_s1 + 1 : 3; end
    end else if (ordy) m_valid = 0;
    chk("out_valid", out_valid, m_valid);
    chk("out_gray", out_gray, m_gray);
    chk("out_id", out_id, m_id);
    chk("acc_cnt0", acc_cnt0, m_c0);
    chk("acc_cnt1", acc_cnt1, m_c1);
    chk("sat_cnt0", s_cnt0, m_s0);
    chk("sat_cnt1", s_cnt1, m_s1);
  endtask

  initial begin
    logic [9:0] tb0[4];
    logic [9:0] tg0[4];
    m_valid = 0; m_gray = 0; m_id = 0; m_last = 1;
    m_c0 = 0; m_c1 = 0; m_s0 = 0; m_s1 = 0;
    tb0 = '{10'h000, 10'h005, 10'h200, 10'h3FF};
    tg0 = '{10'h000, 10'h007, 10'h300, 10'h200};
    #1;
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("reset_valid", out_valid, 0);
    chk("reset_gray", out_gray, 0);
    // Single requester stream.
    for (int i = 0; i < 4; i++) begin
      step(1, tb0[i], 0, 0, 1, 0);
      chk("single_gray", out_gray, tg0[i]);
    end
    chk("single_cnt0", acc_cnt0, 4);
    // Contention straight after reset: 0,1,0,1.
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 10'd3, 1, 10'd6, 1, 0);
      chk("contend_id", out_id, i % 2);
      chk("contend_gray", out_gray, (i % 2) ? 10'd5 : 10'd2);
    end
    // Backpressure with both valid; release must accept the non-last requester.
    for (int i = 0; i < 3; i++) begin
      step(1, 10'd9, 1, 10'd12, 0, 0);
      chk("bp_gray_hold", out_gray, 10'd5);
    end
    step(1, 10'd9, 1, 10'd12, 1, 0);
    chk("bp_release_id", out_id, 0);
    chk("bp_release_gray", out_gray, 10'd13);
    // Sparse req1 traffic with idle gaps, then contention.
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 10'(i + 20), 1, 0);
      step(0, 0, 0, 0, 1, 0);
    end
    step(1, 10'd40, 1, 10'd41, 1, 0);
    chk("sparse_id", out_id, 0);
    // Saturation of the CW=2 counter.
    step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 10'(i), 1, 0);
      chk("sat_seq", s_cnt1, (i < 3) ? i + 1 : 3);
    end
    // Mid-operation reset with a held result and a pending request.
    step(1, 10'd77, 0, 0, 0, 0);
    step(1, 10'd78, 0, 0, 0, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt1", acc_cnt1, 0);
    step(1, 10'd100, 1, 10'd200, 1, 0);
    chk("midrst_first_id", out_id, 0);
    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
